// File: rtl/lc4_divider_iter_if.sv
// Start/busy/valid handshake bundle between a requester and the iterative divider.
// Latency: none (wires only).
// Backpressure: none; requests are accepted only when the divider is idle or done.
interface lc4_divider_iter_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  // Requester side: issues operands, observes status and results.
  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_valid, o_quotient, o_remainder
  );

  // Divider side.
  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_valid, o_quotient, o_remainder
  );
endinterface

// File: rtl/lc4_divider_iter.sv
// Iterative unsigned restoring divider: one quotient bit per cycle.
// Latency: WIDTH+1 cycles from accepted start to the o_valid pulse.
// Backpressure: i_start is ignored while busy; back-to-back start accepted in DONE.
module lc4_divider_iter #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  lc4_divider_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_r;      // partial remainder
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_div0;

  // One restoring step. When the trial fits, the true difference is below the
  // divisor, so a WIDTH-bit subtraction of the low bits is exact.
  assign w_trial  = {r_r, r_q[WIDTH-1]};
  assign w_ge     = (w_trial >= {1'b0, r_div});
  assign w_r_nxt  = w_ge ? (w_trial[WIDTH-1:0] - r_div) : w_trial[WIDTH-1:0];
  assign w_q_nxt  = {r_q[WIDTH-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_div0   = (r_div == '0);
  assign w_accept = bus.i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result latch on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_r    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
    end else begin
      if (w_accept) begin
        r_q   <= bus.i_dividend;
        r_div <= bus.i_divisor;
        r_r   <= '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          // Divide by zero yields 0/0; the step logic alone would give all-ones.
          r_quot <= w_div0 ? '0 : w_q_nxt;
          r_rem  <= w_div0 ? '0 : w_r_nxt;
        end
      end
    end
  end

  assign bus.o_busy      = (r_state == S_RUN);
  assign bus.o_valid     = (r_state == S_DONE);
  assign bus.o_quotient  = r_quot;
  assign bus.o_remainder = r_rem;

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Scoreboard bench for lc4_divider_iter: directed vectors, queue-based checking.
// Latency: expects o_valid exactly 17 cycles after the accepting edge.
// Backpressure: exercises ignored starts, reset abort and back-to-back requests.
module tb_lc4_divider_iter;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  exp_t sb[$];

  lc4_divider_iter_if #(.WIDTH(16)) bus ();

  lc4_divider_iter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(bus.o_quotient), int'(e.q));
        check("remainder", int'(bus.o_remainder), int'(e.r));
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a start for one cycle from a negedge; optionally register the expected result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input bit push);
    exp_t e;
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    if (push) begin
      e.q = q; e.r = r; e.cyc = cyc + 17;
      sb.push_back(e);
    end
    tick(1);
    bus.i_start    = 1'b0;
    bus.i_dividend = 16'($urandom);
    bus.i_divisor  = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    tick(1);
  endtask

  initial begin
    int nv;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    rst = 1'b1;
    tick(3);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_quot", int'(bus.o_quotient), 0);
    check("rst_rem", int'(bus.o_remainder), 0);
    rst = 1'b0;
    tick(2);

    // Basic 100/7 with busy profile over cycles 1..17.
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      check("busy_profile", int'(bus.o_busy), (i <= 16) ? 1 : 0);
      tick(1);
    end
    drain();
    tick(3);
    check("hold_quot", int'(bus.o_quotient), 14);
    check("hold_rem", int'(bus.o_remainder), 2);

    // Edge operands and divide by zero.
    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b1);
    drain();
    issue(16'd3, 16'd10, 16'd0, 16'd3, 1'b1);
    drain();
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b1);
    drain();
    issue(16'd5, 16'd0, 16'd0, 16'd0, 1'b1);
    drain();

    // Start during RUN is ignored.
    nv = n_valid;
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
    tick(4);
    bus.i_start = 1'b1; bus.i_dividend = 16'd9; bus.i_divisor = 16'd3;
    tick(1);
    bus.i_start = 1'b0;
    drain();
    tick(40);
    check("ignored_start_valids", n_valid - nv, 1);

    // Reset in cycle 8 aborts the operation.
    issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0);
    tick(7);
    rst = 1'b1;
    tick(1);
    check("abort_busy", int'(bus.o_busy), 0);
    check("abort_valid", int'(bus.o_valid), 0);
    rst = 1'b0;
    nv = n_valid;
    tick(40);
    check("abort_no_valid", n_valid - nv, 0);
    check("abort_quot", int'(bus.o_quotient), 0);
    check("abort_rem", int'(bus.o_remainder), 0);

    // Back-to-back: second request held during the DONE cycle.
    issue(16'd50, 16'd6, 16'd8, 16'd2, 1'b1);
    tick(15);
    check("b2b_busy_c16", int'(bus.o_busy), 1);
    tick(1);
    check("b2b_done_busy", int'(bus.o_busy), 0);
    check("b2b_done_valid", int'(bus.o_valid), 1);
    issue(16'd77, 16'd8, 16'd9, 16'd5, 1'b1);
    check("b2b_busy_c18", int'(bus.o_busy), 1);
    drain();
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/lc4_divider_iter.md
# lc4_divider_iter

Multi-cycle iterative unsigned divider for the LC4 datapath. It computes quotient and remainder of two 16-bit operands, one quotient bit per cycle, using a start/busy/valid handshake. It sits directly upstream of the LC4 arithmetic unit and supplies that unit's DIV and MOD results.

## Interface
- WIDTH, 16, operand and result width in bits; only 16 is used in LC4.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- i_start  input  1  request strobe; sampled only in IDLE or DONE.
- i_dividend  input  WIDTH  dividend, captured on the accepted i_start edge.
- i_divisor  input  WIDTH  divisor, captured on the accepted i_start edge.
- o_busy  output  1  high while a division is in progress (RUN state).
- o_valid  output  1  one-cycle pulse; results are valid in this cycle.
- o_quotient  output  WIDTH  quotient of the last completed division.
- o_remainder  output  WIDTH  remainder of the last completed division.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE.
- **IDLE:** if i_start=1, capture operands, clear the partial remainder, load the iteration counter with 0, and go to RUN.
- **RUN:** performs one restoring-division step per cycle.
  - Trial value T = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits). R is the partial remainder and Q is the dividend/quotient shift register.
  - If T >= {0, divisor}: R = T - divisor and qbit = 1. Otherwise R = T and qbit = 0.
  - Q = {Q[WIDTH-2:0], qbit}. The counter increments.
  - After WIDTH steps, go to DONE.
- **DONE:** lasts one cycle. o_valid=1 and the results are registered.
  - If i_start=1 in this cycle, the new request is accepted and the next state is RUN (back-to-back operation).
  - Otherwise the next state is IDLE.
- **Divide by zero (divisor=0):** quotient=0 and remainder=0, which is the LC4 convention. Latency is the same as a normal division: the block still runs WIDTH steps and then substitutes zeros at DONE.
- **i_start while in RUN:** ignored. There is no queuing and no error flag.
- **Result outputs:**
  - o_quotient and o_remainder are updated only on the edge that enters DONE.
  - They hold their values through the following IDLE and RUN periods. Intermediate values are never visible.
- All arithmetic is unsigned. The remainder always satisfies remainder < divisor when divisor != 0.

## Timing
- **Reset values:** o_busy=0, o_valid=0, o_quotient=0, o_remainder=0; state=IDLE; internal counter and registers are 0.
- **Latency:** i_start sampled high at the end of cycle 0.
  - o_busy=1 in cycles 1..WIDTH (16 cycles).
  - o_valid=1 and the new results appear in cycle WIDTH+1 (cycle 17).
  - o_busy=0 in the DONE cycle.
- **Throughput:** one result every WIDTH+1 cycles with back-to-back starts.
- **Reset mid-operation:** rst=1 on any edge forces IDLE on that edge.
  - o_busy and o_valid are 0 in the next cycle and o_valid is never pulsed for the aborted operation.
  - Result outputs return to 0.
- **Simultaneous rst and i_start:** rst wins; the request is dropped.
- **Operand inputs:** may change freely after the accepting edge; they are ignored until the next accepted start.

## Test plan
- **Basic division:** reset, then i_start with 100/7 -> o_busy high cycles 1..16; o_valid pulse in cycle 17 with o_quotient=14 and o_remainder=2; outputs hold 14/2 afterwards.
- **Edge operands:**
  - 0xFFFF/1 -> o_quotient=0xFFFF, o_remainder=0.
  - 3/10 -> o_quotient=0, o_remainder=3.
  - 0xFFFF/0xFFFF -> o_quotient=1, o_remainder=0.
- **Divide by zero:** 5/0 -> o_valid in cycle 17, o_quotient=0, o_remainder=0.
- **Ignored start:** start 100/7, then pulse i_start with 9/3 in cycle 5 -> only one o_valid (cycle 17) with 14/2; no second result follows.
- **Reset mid-operation:** start 1000/3, assert rst in cycle 8 -> o_busy=0 in cycle 9; o_valid stays 0 for 40 cycles; outputs read 0.
- **Back-to-back:** start 50/6, hold i_start with 77/8 in the DONE cycle -> o_valid in cycle 17 with 8/2; o_busy from cycle 18; o_valid in cycle 34 with 9/5.
